// File: rtl/memShare_config_pkg.sv
// Shared memory-share configuration: DRC vector width and the DRC1 bit position.
package memShare_config_pkg;

  localparam int unsigned MEMSHARE_DRC_NUM = 4;
  localparam int unsigned MEMSHARE_DRC1    = 1;

endpackage

// File: rtl/msgPass_config_pkg.sv
// Message-pass configuration: job size limits, derived widths and read sequencer states.
package msgPass_config_pkg;

  localparam int unsigned MAX_LAYER_NUM   = 4;
  localparam int unsigned MAX_READ_LEN    = 16;
  localparam int unsigned LAYER_CNT_WIDTH = $clog2(MAX_LAYER_NUM + 1);
  localparam int unsigned READ_LEN_WIDTH  = $clog2(MAX_READ_LEN + 1);
  // A read index only ever spans 0..MAX_READ_LEN-1.
  localparam int unsigned RD_IDX_WIDTH    = $clog2(MAX_READ_LEN);

  typedef enum logic [2:0] {
    StIdle,
    StRead,
    StEnd,
    StGap,
    StDone
  } msgpass_rd_sched_state_e;

endpackage

// File: rtl/msgpass_rd_cnt.sv
// Read-index / layer counter pair for the read sequencer, holding the latched job size
// and flagging the last read of a layer and the last layer of a job.
module msgpass_rd_cnt
  import msgPass_config_pkg::*;
(
  input  logic                       sys_clk,
  input  logic                       rstn,
  input  logic                       load_i,
  input  logic [READ_LEN_WIDTH-1:0]  len_i,
  input  logic [LAYER_CNT_WIDTH-1:0] num_i,
  input  logic                       rd_clr_i,
  input  logic                       rd_en_i,
  input  logic                       layer_en_i,
  output logic [RD_IDX_WIDTH-1:0]    rd_idx_nxt_o,
  output logic [LAYER_CNT_WIDTH-1:0] layer_idx_nxt_o,
  output logic                       rd_last_o,
  output logic                       layer_last_o
);

  logic [READ_LEN_WIDTH-1:0]  len_q;
  logic [LAYER_CNT_WIDTH-1:0] num_q;
  logic [RD_IDX_WIDTH-1:0]    rd_idx_q, rd_idx_d;
  logic [LAYER_CNT_WIDTH-1:0] layer_q, layer_d;

  always_comb begin
    rd_idx_d = rd_idx_q;
    layer_d  = layer_q;
    if (load_i || rd_clr_i) begin
      rd_idx_d = '0;
    end else if (rd_en_i) begin
      rd_idx_d = rd_idx_q + RD_IDX_WIDTH'(1);
    end
    if (load_i) begin
      layer_d = '0;
    end else if (layer_en_i) begin
      layer_d = layer_q + LAYER_CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      len_q    <= '0;
      num_q    <= '0;
      rd_idx_q <= '0;
      layer_q  <= '0;
    end else begin
      if (load_i) begin
        len_q <= len_i;
        num_q <= num_i;
      end
      rd_idx_q <= rd_idx_d;
      layer_q  <= layer_d;
    end
  end

  assign rd_idx_nxt_o    = rd_idx_d;
  assign layer_idx_nxt_o = layer_d;
  assign rd_last_o    = (READ_LEN_WIDTH'(rd_idx_q) + READ_LEN_WIDTH'(1)) == len_q;
  assign layer_last_o = (layer_q + LAYER_CNT_WIDTH'(1)) == num_q;

endmodule

// File: rtl/msgpass_rd_sched.sv
// Layer-by-layer read sequencer feeding the message-pass buffer read address generator.
// Define MSGPASS_RD_SCHED_GAP_EN to insert one idle GAP cycle between layers.
module msgpass_rd_sched
  import msgPass_config_pkg::*;
  import memShare_config_pkg::*;
(
  input  logic                        sys_clk,
  input  logic                        rstn,
  input  logic                        start_i,
  output logic                        start_ready_o,
  input  logic [LAYER_CNT_WIDTH-1:0]  layer_num_i,
  input  logic [READ_LEN_WIDTH-1:0]   read_len_i,
  input  logic [MAX_READ_LEN-1:0]     drc_mask_i,
  input  logic                        abort_i,
  output logic                        buffer_read_begin_o,
  output logic                        buffer_read_end_o,
  output logic                        rd_valid_o,
  output logic [MEMSHARE_DRC_NUM-1:0] is_drc_o,
  output logic [LAYER_CNT_WIDTH-1:0]  layer_idx_o,
  output logic                        done_o,
  output logic                        done_aborted_o
);

  msgpass_rd_sched_state_e state_q, state_d;

  logic                        abort_q, abort_d;
  logic [MAX_READ_LEN-1:0]     mask_q, mask_src;
  logic [READ_LEN_WIDTH-1:0]   len_cl;
  logic [LAYER_CNT_WIDTH-1:0]  num_cl;
  logic                        load, rd_clr, rd_en, layer_en;
  logic [RD_IDX_WIDTH-1:0]     rd_idx_nxt;
  logic [LAYER_CNT_WIDTH-1:0]  layer_nxt;
  logic                        rd_last, layer_last;

  logic                        start_ready_q, start_ready_d;
  logic                        begin_q, begin_d;
  logic                        end_q, end_d;
  logic                        rd_valid_q, rd_valid_d;
  logic [MEMSHARE_DRC_NUM-1:0] is_drc_q, is_drc_d;
  logic [LAYER_CNT_WIDTH-1:0]  layer_q;
  logic                        done_q, done_d;
  logic                        done_ab_q, done_ab_d;

  assign len_cl = (read_len_i > READ_LEN_WIDTH'(MAX_READ_LEN)) ?
                  READ_LEN_WIDTH'(MAX_READ_LEN) : read_len_i;
  assign num_cl = (layer_num_i > LAYER_CNT_WIDTH'(MAX_LAYER_NUM)) ?
                  LAYER_CNT_WIDTH'(MAX_LAYER_NUM) : layer_num_i;

  msgpass_rd_cnt u_rd_cnt (
    .sys_clk         (sys_clk),
    .rstn            (rstn),
    .load_i          (load),
    .len_i           (len_cl),
    .num_i           (num_cl),
    .rd_clr_i        (rd_clr),
    .rd_en_i         (rd_en),
    .layer_en_i      (layer_en),
    .rd_idx_nxt_o    (rd_idx_nxt),
    .layer_idx_nxt_o (layer_nxt),
    .rd_last_o       (rd_last),
    .layer_last_o    (layer_last)
  );

  always_comb begin
    state_d  = state_q;
    abort_d  = abort_q;
    load     = 1'b0;
    rd_clr   = 1'b0;
    rd_en    = 1'b0;
    layer_en = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          load    = 1'b1;
          abort_d = 1'b0;
          state_d = (len_cl == '0 || num_cl == '0) ? StDone : StRead;
        end
      end
      StRead: begin
        abort_d = abort_q | abort_i;
        // The aborting cycle's read still issues; only the next cycle becomes END.
        if (abort_i || rd_last) begin
          state_d = StEnd;
        end else begin
          rd_en = 1'b1;
        end
      end
      StEnd: begin
        abort_d = abort_q | abort_i;
        if (abort_d || layer_last) begin
          state_d = StDone;
        end else begin
          rd_clr   = 1'b1;
          layer_en = 1'b1;
`ifdef MSGPASS_RD_SCHED_GAP_EN
          state_d  = StGap;
`else
          state_d  = StRead;
`endif
        end
      end
`ifdef MSGPASS_RD_SCHED_GAP_EN
      StGap: begin
        abort_d = abort_q | abort_i;
        state_d = abort_d ? StDone : StRead;
      end
`endif
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs are computed from the next state so every pulse comes straight off a flop.
  always_comb begin
    mask_src      = load ? drc_mask_i : mask_q;
    start_ready_d = (state_d == StIdle);
    rd_valid_d    = (state_d == StRead);
    begin_d       = (state_d == StRead) && (state_q != StRead);
    end_d         = (state_d == StEnd);
    done_d        = (state_d == StDone);
    done_ab_d     = (state_d == StDone) && abort_d;
    is_drc_d      = '0;
    is_drc_d[MEMSHARE_DRC1] = rd_valid_d & mask_src[rd_idx_nxt];
  end

  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= StIdle;
      abort_q       <= 1'b0;
      mask_q        <= '0;
      start_ready_q <= 1'b1;
      begin_q       <= 1'b0;
      end_q         <= 1'b0;
      rd_valid_q    <= 1'b0;
      is_drc_q      <= '0;
      layer_q       <= '0;
      done_q        <= 1'b0;
      done_ab_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      abort_q       <= abort_d;
      if (load) begin
        mask_q <= drc_mask_i;
      end
      start_ready_q <= start_ready_d;
      begin_q       <= begin_d;
      end_q         <= end_d;
      rd_valid_q    <= rd_valid_d;
      is_drc_q      <= is_drc_d;
      layer_q       <= layer_nxt;
      done_q        <= done_d;
      done_ab_q     <= done_ab_d;
    end
  end

  assign start_ready_o       = start_ready_q;
  assign buffer_read_begin_o = begin_q;
  assign buffer_read_end_o   = end_q;
  assign rd_valid_o          = rd_valid_q;
  assign is_drc_o            = is_drc_q;
  assign layer_idx_o         = layer_q;
  assign done_o              = done_q;
  assign done_aborted_o      = done_ab_q;

endmodule

// File: tb/tb_msgpass_rd_sched.sv
// Directed bench for msgpass_rd_sched; per-cycle outputs are packed into bit-vectors
// (bit k = value in cycle k after start accept) and compared with hand-computed constants.
module tb_msgpass_rd_sched;
  import msgPass_config_pkg::*;
  import memShare_config_pkg::*;

  logic                        sys_clk;
  logic                        rstn;
  logic                        start_i;
  logic                        start_ready_o;
  logic [LAYER_CNT_WIDTH-1:0]  layer_num_i;
  logic [READ_LEN_WIDTH-1:0]   read_len_i;
  logic [MAX_READ_LEN-1:0]     drc_mask_i;
  logic                        abort_i;
  logic                        buffer_read_begin_o;
  logic                        buffer_read_end_o;
  logic                        rd_valid_o;
  logic [MEMSHARE_DRC_NUM-1:0] is_drc_o;
  logic [LAYER_CNT_WIDTH-1:0]  layer_idx_o;
  logic                        done_o;
  logic                        done_aborted_o;

  int n_checks;
  int n_errors;

  logic [31:0] v_begin, v_end, v_valid, v_done, v_abt, v_drc1, v_drc_oth, v_rdy, v_layer_nz;
  logic [MEMSHARE_DRC_NUM-1:0] drc1_bit;

  msgpass_rd_sched dut (
    .sys_clk             (sys_clk),
    .rstn                (rstn),
    .start_i             (start_i),
    .start_ready_o       (start_ready_o),
    .layer_num_i         (layer_num_i),
    .read_len_i          (read_len_i),
    .drc_mask_i          (drc_mask_i),
    .abort_i             (abort_i),
    .buffer_read_begin_o (buffer_read_begin_o),
    .buffer_read_end_o   (buffer_read_end_o),
    .rd_valid_o          (rd_valid_o),
    .is_drc_o            (is_drc_o),
    .layer_idx_o         (layer_idx_o),
    .done_o              (done_o),
    .done_aborted_o      (done_aborted_o)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called #1 after a clock edge; the next edge accepts the job (cycle 0).
  task automatic start_job(input int num, input int len, input logic [15:0] mask,
                           input logic abt);
    layer_num_i = LAYER_CNT_WIDTH'(num);
    read_len_i  = READ_LEN_WIDTH'(len);
    drc_mask_i  = mask;
    abort_i     = abt;
    start_i     = 1'b1;
    @(posedge sys_clk);
    #1;
    start_i = 1'b0;
    abort_i = 1'b0;
  endtask

  task automatic capture(input int n, input int abort_cyc, input logic hold);
    v_begin = '0; v_end = '0; v_valid = '0; v_done = '0; v_abt = '0;
    v_drc1 = '0; v_drc_oth = '0; v_rdy = '0; v_layer_nz = '0;
    for (int k = 1; k <= n; k++) begin
      v_begin    = v_begin    | (32'(buffer_read_begin_o) << k);
      v_end      = v_end      | (32'(buffer_read_end_o) << k);
      v_valid    = v_valid    | (32'(rd_valid_o) << k);
      v_done     = v_done     | (32'(done_o) << k);
      v_abt      = v_abt      | (32'(done_aborted_o) << k);
      v_drc1     = v_drc1     | (32'(|(is_drc_o & drc1_bit)) << k);
      v_drc_oth  = v_drc_oth  | (32'(|(is_drc_o & ~drc1_bit)) << k);
      v_rdy      = v_rdy      | (32'(start_ready_o) << k);
      v_layer_nz = v_layer_nz | (32'(layer_idx_o != '0) << k);
      abort_i = (k == abort_cyc);
      start_i = hold && (k < n);
      @(posedge sys_clk);
      #1;
    end
    abort_i = 1'b0;
    start_i = 1'b0;
  endtask

  initial begin
    n_checks    = 0;
    n_errors    = 0;
    drc1_bit    = '0;
    drc1_bit[MEMSHARE_DRC1] = 1'b1;
    rstn        = 1'b0;
    start_i     = 1'b0;
    abort_i     = 1'b0;
    layer_num_i = '0;
    read_len_i  = '0;
    drc_mask_i  = '0;

    #12;
    check("rst_ready", 32'(start_ready_o), 32'h1);
    check("rst_begin", 32'(buffer_read_begin_o), 32'h0);
    check("rst_end", 32'(buffer_read_end_o), 32'h0);
    check("rst_valid", 32'(rd_valid_o), 32'h0);
    check("rst_drc", 32'(is_drc_o), 32'h0);
    check("rst_done", 32'({done_o, done_aborted_o}), 32'h0);
    check("rst_layer", 32'(layer_idx_o), 32'h0);
    rstn = 1'b1;
    @(posedge sys_clk);
    #1;

    // Basic two-layer job
    start_job(2, 3, 16'h0000, 1'b0);
    capture(12, 0, 1'b0);
`ifdef MSGPASS_RD_SCHED_GAP_EN
    check("basic_begin", v_begin, 32'h42);
    check("basic_valid", v_valid, 32'h1CE);
    check("basic_end", v_end, 32'h210);
    check("basic_done", v_done, 32'h400);
    check("basic_ready", v_rdy, 32'h1800);
`else
    check("basic_begin", v_begin, 32'h22);
    check("basic_valid", v_valid, 32'hEE);
    check("basic_end", v_end, 32'h110);
    check("basic_done", v_done, 32'h200);
    check("basic_ready", v_rdy, 32'h1C00);
`endif
    check("basic_aborted", v_abt, 32'h0);
    check("basic_layer", v_layer_nz, 32'h1FE0);
    check("basic_drc", v_drc1 | v_drc_oth, 32'h0);

    // DRC mask; abort_i during the accept cycle (IDLE) must be ignored
    start_job(1, 4, 16'h000A, 1'b1);
    capture(8, 0, 1'b0);
    check("drc_valid", v_valid, 32'h1E);
    check("drc_drc1", v_drc1, 32'h14);
    check("drc_other", v_drc_oth, 32'h0);
    check("drc_end", v_end, 32'h20);
    check("drc_done", v_done, 32'h40);
    check("drc_aborted", v_abt, 32'h0);

    // Degenerate sizes
    start_job(2, 0, 16'hFFFF, 1'b0);
    capture(3, 0, 1'b0);
    check("len0_done", v_done, 32'h2);
    check("len0_rd", v_begin | v_end | v_valid | v_abt, 32'h0);
    check("len0_ready", v_rdy, 32'hC);
    start_job(0, 3, 16'hFFFF, 1'b0);
    capture(3, 0, 1'b0);
    check("num0_done", v_done, 32'h2);
    check("num0_rd", v_begin | v_end | v_valid | v_abt, 32'h0);

    // Clamping: 20 reads -> 16, 7 layers -> 4
    start_job(1, 20, 16'h0000, 1'b0);
    capture(20, 0, 1'b0);
    check("len20_valid", v_valid, 32'h1FFFE);
    check("len20_end", v_end, 32'h20000);
    check("len20_done", v_done, 32'h40000);
    start_job(7, 1, 16'h0000, 1'b0);
    capture(13, 0, 1'b0);
`ifdef MSGPASS_RD_SCHED_GAP_EN
    check("num7_valid", v_valid, 32'h492);
    check("num7_end", v_end, 32'h924);
    check("num7_done", v_done, 32'h1000);
`else
    check("num7_valid", v_valid, 32'hAA);
    check("num7_end", v_end, 32'h154);
    check("num7_done", v_done, 32'h200);
`endif

    // Abort at read 2 of layer 1
    start_job(3, 8, 16'h0000, 1'b0);
`ifdef MSGPASS_RD_SCHED_GAP_EN
    capture(18, 13, 1'b0);
    check("abort_begin", v_begin, 32'h802);
    check("abort_valid", v_valid, 32'h39FE);
    check("abort_end", v_end, 32'h4200);
    check("abort_done", v_done, 32'h8000);
    check("abort_flag", v_abt, 32'h8000);
`else
    capture(18, 12, 1'b0);
    check("abort_begin", v_begin, 32'h402);
    check("abort_valid", v_valid, 32'h1DFE);
    check("abort_end", v_end, 32'h2200);
    check("abort_done", v_done, 32'h4000);
    check("abort_flag", v_abt, 32'h4000);
`endif

    // Abort asserted in END of layer 0 stops before layer 1
    start_job(2, 2, 16'h0000, 1'b0);
    capture(6, 3, 1'b0);
    check("abend_begin", v_begin, 32'h2);
    check("abend_valid", v_valid, 32'h6);
    check("abend_done", v_done, 32'h10);
    check("abend_flag", v_abt, 32'h10);

    // start_i held high while busy is ignored
    start_job(1, 2, 16'h0000, 1'b0);
    capture(5, 0, 1'b1);
    check("busy_begin", v_begin, 32'h2);
    check("busy_valid", v_valid, 32'h6);
    check("busy_done", v_done, 32'h10);
    check("busy_ready", v_rdy, 32'h20);

    // Reset during READ
    start_job(2, 8, 16'hFFFF, 1'b0);
    capture(3, 0, 1'b0);
    check("prerst_valid", 32'(rd_valid_o), 32'h1);
    #2;
    rstn = 1'b0;
    #1;
    check("midrst_valid", 32'(rd_valid_o), 32'h0);
    check("midrst_drc", 32'(is_drc_o), 32'h0);
    check("midrst_ready", 32'(start_ready_o), 32'h1);
    check("midrst_misc",
          32'({buffer_read_begin_o, buffer_read_end_o, done_o, done_aborted_o, layer_idx_o}),
          32'h0);
    #2;
    rstn = 1'b1;
    @(posedge sys_clk);
    #1;
    capture(3, 0, 1'b0);
    check("postrst_quiet", v_begin | v_end | v_valid | v_done, 32'h0);
    check("postrst_ready", v_rdy, 32'hE);
    start_job(1, 1, 16'h0001, 1'b0);
    capture(4, 0, 1'b0);
    check("postrst_begin", v_begin, 32'h2);
    check("postrst_drc1", v_drc1, 32'h2);
    check("postrst_end", v_end, 32'h4);
    check("postrst_done", v_done, 32'h8);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
